// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: mux select encoding and the
// sequencing FSM state type. Used by uart_tx_ctrl and by Max_TX.
package uart_pkg;

    // Max_TX select contract; codes 12..15 are never driven.
    localparam logic [3:0] SEL_IDLE  = 4'd0;   // line high
    localparam logic [3:0] SEL_START = 4'd1;   // start bit (0)
    localparam logic [3:0] SEL_D0    = 4'd2;   // data[0], LSB first
    localparam logic [3:0] SEL_D7    = 4'd9;   // data[7]
    localparam logic [3:0] SEL_PAR   = 4'd10;  // even parity of data
    localparam logic [3:0] SEL_STOP  = 4'd11;  // stop bit (1)

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and raises
// tc_o on the last cycle of each bit period. clr_i restarts the period.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count only matters while a frame is running.
    assign tc_o = en_i && (cnt_q == LAST);

    // Next count: clear wins, then wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer feeding the Max_TX bit-select mux.
// Handshake: a byte is accepted on any rising edge where tx_start=1 and
// tx_ready=1 (block in IDLE); tx_start is ignored while tx_ready=0.
// The accepted byte is held on data_out for the whole frame while sel
// steps start, data[0..7], optional parity, stop, one bit period each.
// All outputs come straight from registers.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic [7:0] data_out,
    output logic [3:0] sel,
    output logic       busy,
    output logic       tx_done
);

    tx_state_e  state_q, state_d;
    logic [3:0] sel_q, sel_d;
    logic [7:0] data_q, data_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic       done_q, done_d;
    logic       accept;
    logic       bit_tc;

    assign accept = (state_q == ST_IDLE) && tx_start;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .en_i  (state_q != ST_IDLE),
        .tc_o  (bit_tc)
    );

    // Next state, select and latch; status outputs follow the next state
    // so they are registered yet line up with sel.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    data_d  = tx_data;
                    sel_d   = SEL_START;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_tc) begin
                    sel_d   = SEL_D0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tc) begin
                    if (sel_q != SEL_D7) begin
                        sel_d = sel_q + 4'd1;
                    end else if (PARITY_EN) begin
                        sel_d   = SEL_PAR;
                        state_d = ST_PARITY;
                    end else begin
                        sel_d   = SEL_STOP;
                        state_d = ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tc) begin
                    sel_d   = SEL_STOP;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tc) begin
                    sel_d   = SEL_IDLE;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                sel_d   = SEL_IDLE;
                state_d = ST_IDLE;
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset returns the block to idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_IDLE;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready = ready_q;
    assign data_out = data_q;
    assign sel      = sel_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: one instance with parity, one without, driven
// by the same inputs and each compared every cycle to a frame-level model.
module tb_uart_tx_ctrl;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;

    always #5 clk = ~clk;

    // index 0: PARITY_EN=0, index 1: PARITY_EN=1
    logic       tx_ready_w [2];
    logic [7:0] data_out_w [2];
    logic [3:0] sel_w      [2];
    logic       busy_w     [2];
    logic       tx_done_w  [2];

    uart_tx_ctrl #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0)) u_dut_nopar (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_ready (tx_ready_w[0]),
        .data_out (data_out_w[0]),
        .sel      (sel_w[0]),
        .busy     (busy_w[0]),
        .tx_done  (tx_done_w[0])
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1)) u_dut_par (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_ready (tx_ready_w[1]),
        .data_out (data_out_w[1]),
        .sel      (sel_w[1]),
        .busy     (busy_w[1]),
        .tx_done  (tx_done_w[1])
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is a list of bit positions, each N cycles long; sel is the
    // position at (cycles since acceptance)/N.
    bit         m_active [2];
    int         m_k      [2];
    logic [7:0] m_data   [2];
    bit         m_done   [2];
    logic [7:0] exp_q[$];
    string      names [2] = '{"nopar", "par"};

    function automatic int frame_len(input int inst);
        return (inst == 1 ? 11 : 10) * N;
    endfunction

    function automatic logic [3:0] exp_sel(input int inst, input int k);
        int idx;
        idx = k / N;
        if (idx == 0) return 4'd1;
        if (idx <= 8) return 4'(idx + 1);
        if (idx == 9 && inst == 1) return 4'd10;
        return 4'd11;
    endfunction

    // Serial line that Max_TX would produce for a given select/data pair.
    function automatic logic line_of(input logic [3:0] s, input logic [7:0] d);
        if (s == 4'd0 || s == 4'd11) return 1'b1;
        if (s == 4'd1) return 1'b0;
        if (s >= 4'd2 && s <= 4'd9) return d[s - 4'd2];
        if (s == 4'd10) return ^d;
        return 1'bx;
    endfunction

    // Advance the model at each edge, then compare every output.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_active[i] = 1'b0;
                m_k[i]      = 0;
                m_data[i]   = 8'h00;
                m_done[i]   = 1'b0;
            end else if (m_active[i]) begin
                m_k[i]++;
                m_done[i] = 1'b0;
                if (m_k[i] == frame_len(i)) begin
                    m_active[i] = 1'b0;
                    m_done[i]   = 1'b1;
                end
            end else begin
                m_done[i] = 1'b0;
                if (tx_start) begin
                    m_active[i] = 1'b1;
                    m_k[i]      = 0;
                    m_data[i]   = tx_data;
                    if (i == 1) exp_q.push_back(tx_data);
                end
            end
        end
        if (!rst_n) exp_q.delete();
        #2;
        for (int i = 0; i < 2; i++) begin
            check_eq({names[i], ".sel"},      sel_w[i],      m_active[i] ? exp_sel(i, m_k[i]) : 4'd0);
            check_eq({names[i], ".data_out"}, data_out_w[i], m_data[i]);
            check_eq({names[i], ".busy"},     busy_w[i],     m_active[i]);
            check_eq({names[i], ".tx_ready"}, tx_ready_w[i], !m_active[i]);
            check_eq({names[i], ".tx_done"},  tx_done_w[i],  m_done[i]);
        end
        if (tx_done_w[1]) begin
            check_eq("sb_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) check_eq("sb_data", data_out_w[1], exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_vals(input string when);
        for (int i = 0; i < 2; i++) begin
            check_eq({when, ".", names[i], ".sel"},      sel_w[i],      0);
            check_eq({when, ".", names[i], ".busy"},     busy_w[i],     0);
            check_eq({when, ".", names[i], ".tx_ready"}, tx_ready_w[i], 1);
            check_eq({when, ".", names[i], ".data_out"}, data_out_w[i], 8'h00);
            check_eq({when, ".", names[i], ".tx_done"},  tx_done_w[i],  0);
        end
    endtask

    // Send one byte from idle and time tx_done on both instances.
    task automatic run_frame(input logic [7:0] d, input bit line_chk);
        int  done_par;
        int  done_nop;
        bit  saw10;
        int  exp_line [11];
        exp_line = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        done_par = -1;
        done_nop = -1;
        saw10    = 1'b0;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #3;
            if (c == 0) tx_start = 1'b0;
            if (sel_w[0] == 4'd10) saw10 = 1'b1;
            if (line_chk && (c % N == 2) && (c / N < 11))
                check_eq("line_par", line_of(sel_w[1], data_out_w[1]), exp_line[c / N]);
            if (tx_done_w[1] && done_par < 0) done_par = c;
            if (tx_done_w[0] && done_nop < 0) done_nop = c;
        end
        check_eq("done_latency_par", done_par, 11 * N);
        check_eq("done_latency_nopar", done_nop, 10 * N);
        check_eq("nopar_no_sel10", saw10, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;

        repeat (2) @(posedge clk);
        #3;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // idle sweep: data changes without a request do nothing
        repeat (20) begin
            @(negedge clk);
            tx_data  = 8'($urandom);
            tx_start = 1'b0;
        end

        // directed frames
        run_frame(8'hA5, 1'b1);
        run_frame(8'hFF, 1'b0);

        // request during a frame is ignored
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (9) @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(posedge clk);
        #3;
        tx_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq({"ignore.", names[i], ".data_out"}, data_out_w[i], 8'h3C);
            check_eq({"ignore.", names[i], ".tx_ready"}, tx_ready_w[i], 0);
        end
        repeat (50) @(negedge clk);

        // back-to-back: new byte presented in the done cycle
        @(negedge clk);
        tx_data  = 8'h12;
        tx_start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk);
            #3;
            if (tx_done_w[1]) found = 1'b1;
        end
        check_eq("b2b_done_seen", found, 1);
        check_eq("b2b_done_sel", sel_w[1], 0);
        tx_data = 8'h34;
        @(posedge clk);
        #3;
        tx_start = 1'b0;
        check_eq("b2b_sel", sel_w[1], 1);
        check_eq("b2b_data", data_out_w[1], 8'h34);
        repeat (100) @(negedge clk);

        // reset in the middle of the data bits
        @(negedge clk);
        tx_data  = 8'($urandom);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (sel_w[1] == 4'd5) found = 1'b1;
        end
        check_eq("reach_sel5", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(8'($urandom), 1'b0);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            tx_data  = 8'($urandom);
            tx_start = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        tx_start = 1'b0;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
